// File: rtl/avr_sram_fifo.sv
// AVR external-memory window onto a pair of byte FIFOs: TX carries AVR writes out
// to a stream port, RX carries an inbound stream back to AVR reads.

module avr_sram_fifo_q #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [7:0]             i_data,
    output logic [7:0]             o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_head  = r_mem[r_rd];

    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr] <= i_data;
    end
endmodule

// Read-access FSM
// state   | meaning
// RD_IDLE | no read in progress; cs&oe here is phase 1 (wait_o=1, capture dout)
// RD_DONE | phase 2: wait_o=0, dout valid, RX pops if a DATA read captured data
// RD_HOLD | read finished, waiting for cs&oe to drop
module avr_sram_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       oe,
    input  logic       we,
    input  logic [2:0] adr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       wait_o,
    output logic       irq,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_RXCNT  = 3'd2;
    localparam logic [2:0] A_TXCNT  = 3'd3;
    localparam logic [2:0] A_CTRL   = 3'd4;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_DONE,
        RD_HOLD
    } rd_state_t;

    rd_state_t     r_rd_state;
    rd_state_t     w_rd_next;
    logic          r_we_d;
    logic          r_rd_pop;
    logic          r_txovf;
    logic          r_irqen;
    logic [7:0]    r_dout;

    logic          w_acc_rd;
    logic          w_acc_wr;
    logic          w_wr_fire;
    logic          w_wr_data;
    logic          w_wr_ctrl;
    logic          w_wait;
    logic          w_rd_capture;
    logic          w_rx_pop;
    logic [7:0]    w_rd_mux;

    logic [7:0]    w_tx_head;
    logic [CW-1:0] w_tx_count;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic [7:0]    w_rx_head;
    logic [CW-1:0] w_rx_count;
    logic          w_rx_full;
    logic          w_rx_empty;

    assign w_acc_rd  = cs & oe;
    assign w_acc_wr  = cs & we;
    assign w_wr_fire = w_acc_wr & ~r_we_d;
    assign w_wr_data = w_wr_fire & (adr == A_DATA);
    assign w_wr_ctrl = w_wr_fire & (adr == A_CTRL);

    avr_sram_fifo_q #(.DEPTH(DEPTH)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_wr_data),
        .i_pop   (tx_ready),
        .i_flush (w_wr_ctrl & din[1]),
        .i_data  (din),
        .o_head  (w_tx_head),
        .o_count (w_tx_count),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    avr_sram_fifo_q #(.DEPTH(DEPTH)) u_rx (
        .clk     (clk),
        .rst     (rst),
        .i_push  (rx_valid),
        .i_pop   (w_rx_pop),
        .i_flush (w_wr_ctrl & din[0]),
        .i_data  (rx_data),
        .o_head  (w_rx_head),
        .o_count (w_rx_count),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    always_comb begin
        w_rd_next    = r_rd_state;
        w_wait       = 1'b0;
        w_rd_capture = 1'b0;
        w_rx_pop     = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                if (w_acc_rd) begin
                    w_wait       = 1'b1;
                    w_rd_capture = 1'b1;
                    w_rd_next    = RD_DONE;
                end
            end
            RD_DONE: begin
                if (w_acc_rd) begin
                    w_rx_pop  = r_rd_pop;
                    w_rd_next = RD_HOLD;
                end else begin
                    w_rd_next = RD_IDLE;
                end
            end
            RD_HOLD: begin
                if (!w_acc_rd) w_rd_next = RD_IDLE;
            end
            default: w_rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        w_rd_mux = 8'h00;
        case (adr)
            A_DATA:   w_rd_mux = w_rx_empty ? 8'h00 : w_rx_head;
            A_STATUS: w_rd_mux = {r_irqen, 2'b00, r_txovf, w_rx_full,
                                  w_tx_empty, w_tx_full, ~w_rx_empty};
            A_RXCNT:  w_rd_mux = 8'(w_rx_count);
            A_TXCNT:  w_rd_mux = 8'(w_tx_count);
            A_CTRL:   w_rd_mux = {r_irqen, 7'b0};
            default:  w_rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rd_state <= RD_IDLE;
        else     r_rd_state <= w_rd_next;
    end

    // r_we_d resets high so a write strobe held through reset must drop before it acts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we_d   <= 1'b1;
            r_rd_pop <= 1'b0;
            r_txovf  <= 1'b0;
            r_irqen  <= 1'b0;
            r_dout   <= 8'h00;
        end else begin
            r_we_d <= w_acc_wr;
            if (w_rd_capture) begin
                r_dout   <= w_rd_mux;
                r_rd_pop <= (adr == A_DATA) & ~w_rx_empty;
            end
            if (w_wr_data && w_tx_full)      r_txovf <= 1'b1;
            else if (w_wr_ctrl && din[2])    r_txovf <= 1'b0;
            if (w_wr_ctrl) r_irqen <= din[7];
        end
    end

    assign dout     = r_dout;
    assign wait_o   = w_wait & ~rst;
    assign irq      = r_irqen & ~w_rx_empty;
    assign tx_data  = w_tx_head;
    assign tx_valid = ~w_tx_empty;
    assign rx_ready = ~w_rx_full & ~rst;
endmodule

// File: doc/avr_sram_fifo.md
AVR_SRAM_FIFO -- requirements
Module: avr_sram_fifo

Interface
REQ-001 Parameter DEPTH, default 16: entries per FIFO; power of two, 2..128.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 cs  input  1  window select from AVR external data memory bus.
REQ-005 oe  input  1  read strobe; valid only with cs.
REQ-006 we  input  1  write strobe; valid only with cs.
REQ-007 adr  input  3  register offset within window.
REQ-008 din  input  8  write data from AVR.
REQ-009 dout  output  8  read data to AVR.
REQ-010 wait_o  output  1  stall request to AVR bus.
REQ-011 irq  output  1  interrupt request, level.
REQ-012 tx_data  output  8  outbound stream data.
REQ-013 tx_valid  output  1  outbound data available.
REQ-014 tx_ready  input  1  consumer accepts tx_data.
REQ-015 rx_data  input  8  inbound stream data.
REQ-016 rx_valid  input  1  producer offers rx_data.
REQ-017 rx_ready  output  1  block accepts rx_data.

Function
REQ-018 Register map: 0 DATA, 1 STATUS, 2 RXCNT, 3 TXCNT, 4 CTRL; offsets 5-7 read 0x00, writes ignored.
REQ-019 Two independent FIFOs of DEPTH x 8: TX (AVR to stream), RX (stream to AVR); counts are clog2(DEPTH)+1 bits wide, zero-extended to 8 on read.
REQ-020 Write: action taken once per access, on the first clk edge where cs&we is high after a cycle where it was low; wait_o never asserted for writes.
REQ-021 Write DATA: pushes din to TX if not full; if full, the data is dropped and TXOVF is set.
REQ-022 Write CTRL: bit0=1 flushes RX, bit1=1 flushes TX, bit2=1 clears TXOVF; bit7 is stored as IRQEN; other bits ignored.
REQ-023 Read: in the first cycle of cs&oe, wait_o=1 (combinational) and read data is captured into the dout register; in the second cycle, wait_o=0 and dout is valid; wait_o stays 0 until cs&oe drops.
REQ-024 Read DATA: captures the RX head; pops RX on the completing (wait_o=0) cycle; if RX is empty, returns 0x00 with no pop.
REQ-025 STATUS bits: [0] RX not empty, [1] TX full, [2] TX empty, [3] RX full, [4] TXOVF, [7] IRQEN; others 0.
REQ-026 dout holds its last value when no read is in progress.
REQ-027 tx_valid = TX not empty; tx_data = TX head (registered from storage, no bubble); pop when tx_valid&tx_ready.
REQ-028 rx_ready = RX not full; push when rx_valid&rx_ready.
REQ-029 Simultaneous push and pop on one FIFO: both occur and the count is unchanged; push on a full FIFO is refused even if a pop occurs in the same cycle.
REQ-030 Flush in the same cycle as a push or pop on that FIFO: flush wins and the count becomes 0.
REQ-031 Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-032 irq = IRQEN & RX not empty.
REQ-033 An AVR read pop and a stream push on RX in the same cycle follow REQ-029.

Reset
REQ-034 rst=1 forces asynchronously: both FIFOs empty, TXOVF=0, IRQEN=0, dout=0x00, read-phase and write-edge state cleared.
REQ-035 During reset: wait_o=0, irq=0, tx_valid=0, rx_ready=0.
REQ-036 Reset mid-access: a read in progress is abandoned; after release, a still-asserted cs&oe begins a new read at phase 1; a still-asserted cs&we does not re-trigger until it is deasserted.

Verification
REQ-037 Write DATA 0x11, 0x22, 0x33 with tx_ready=0 -> TXCNT=3, tx_valid=1, tx_data=0x11; then tx_ready=1 for 3 cycles -> 0x11, 0x22, 0x33 out and TX empty.
REQ-038 Fill TX with DEPTH writes, then 1 more -> STATUS[1]=1, STATUS[4]=1, TXCNT=DEPTH; write CTRL=0x04 -> STATUS[4]=0.
REQ-039 Stream 0xA5 into RX with CTRL=0x80 -> irq=1; read DATA -> wait_o high 1 cycle, dout=0xA5, RXCNT=0, irq=0.
REQ-040 Read DATA with RX empty -> dout=0x00, RXCNT stays 0, wait_o pattern 1 then 0.
REQ-041 RX full, with an AVR pop and rx_valid=1 in the same cycle -> push refused, RXCNT=DEPTH-1; CTRL=0x03 with a concurrent push -> both counts 0.
REQ-042 Assert rst during the first read cycle -> wait_o=0, dout=0x00, FIFOs empty; release with cs&oe still high -> fresh two-cycle read.
